// File: rtl/poly_voice_engine_if.sv
// Note-command, tick and mixed-sample signals between the SPI decoder/DAC glue and the voice engine.
interface poly_voice_engine_if #(
   parameter int NUM_VOICES = 16,
   parameter int PHASE_W    = 32,
   parameter int VEL_W      = 7,
   parameter int OUT_W      = 24
);
   localparam int VIDX_W = $clog2(NUM_VOICES);

   logic                     i_cmd_valid;
   logic                     i_cmd_note_on;
   logic [VIDX_W-1:0]        i_cmd_voice;
   logic [PHASE_W-1:0]       i_cmd_tuning;
   logic [VEL_W-1:0]         i_cmd_velocity;
   logic [1:0]               i_wave_select;
   logic [7:0]               i_master_gain;
   logic                     i_sample_tick;
   logic signed [OUT_W-1:0]  o_sample;
   logic                     o_sample_valid;
   logic                     o_busy;
   logic                     o_overrun;

   modport master (
      output i_cmd_valid, i_cmd_note_on, i_cmd_voice, i_cmd_tuning, i_cmd_velocity,
      output i_wave_select, i_master_gain, i_sample_tick,
      input  o_sample, o_sample_valid, o_busy, o_overrun
   );

   modport slave (
      input  i_cmd_valid, i_cmd_note_on, i_cmd_voice, i_cmd_tuning, i_cmd_velocity,
      input  i_wave_select, i_master_gain, i_sample_tick,
      output o_sample, o_sample_valid, o_busy, o_overrun
   );
endinterface

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic voice engine: phase accumulate, waveform, velocity scale,
// accumulate over all voices, then master gain with saturation once per sample tick.
module poly_voice_engine #(
   parameter int NUM_VOICES = 16,
   parameter int PHASE_W    = 32,
   parameter int SAMPLE_W   = 16,
   parameter int VEL_W      = 7,
   parameter int OUT_W      = 24,
   localparam int VIDX_W    = $clog2(NUM_VOICES)
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   poly_voice_engine_if.slave bus
);
   localparam int ACC_W  = SAMPLE_W + VIDX_W;
   localparam int PROD_W = ACC_W + 9;
   localparam int CMP_W  = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUTPUT} state_t;

   state_t state, state_nxt;
   logic [VIDX_W-1:0] scan_idx;
   logic tick_ok, issue, last_issue, drain_done;

   logic                gate     [NUM_VOICES];
   logic [PHASE_W-1:0]  tuning   [NUM_VOICES];
   logic [PHASE_W-1:0]  phase    [NUM_VOICES];
   logic [VEL_W-1:0]    velocity [NUM_VOICES];

   logic                       vld_p1, vld_p2;
   logic                       gate_p1;
   logic [VEL_W-1:0]           vel_p1, vel_p2;
   logic [SAMPLE_W:0]          top_p1;
   logic signed [SAMPLE_W-1:0] sample_p2, scaled_p2;
   logic signed [ACC_W-1:0]    acc;
   logic signed [OUT_W-1:0]    sample_q;
   logic                       overrun_q;

   function automatic logic signed [SAMPLE_W-1:0] wave_gen(input logic [SAMPLE_W:0] top,
                                                          input logic [1:0] sel,
                                                          input logic g);
      logic signed [SAMPLE_W-1:0] peak, res;
      logic [SAMPLE_W-1:0] t;
      peak = '0;
      peak[SAMPLE_W-2:0] = '1;
      t = top[SAMPLE_W-1:0];
      res = '0;
      if (g) begin
         case (sel)
            2'd0:    res = $signed({~top[SAMPLE_W], top[SAMPLE_W-1:1]});
            2'd1:    res = top[SAMPLE_W] ? -peak : peak;
            2'd2:    res = top[SAMPLE_W] ? peak - $signed(t)
                                         : $signed({~t[SAMPLE_W-1], t[SAMPLE_W-2:0]});
            default: res = '0;
         endcase
      end
      return res;
   endfunction

   // Floor division by 2^VEL_W; |velocity| < 2^VEL_W so the result always fits SAMPLE_W.
   function automatic logic signed [SAMPLE_W-1:0] scale_vel(input logic signed [SAMPLE_W-1:0] s,
                                                           input logic [VEL_W-1:0] v);
      logic signed [SAMPLE_W+VEL_W:0] prod;
      prod = s * $signed({1'b0, v});
      return $signed(prod[SAMPLE_W+VEL_W-1:VEL_W]);
   endfunction

   function automatic logic signed [OUT_W-1:0] apply_gain(input logic signed [ACC_W-1:0] a,
                                                         input logic [7:0] g);
      logic signed [PROD_W-1:0] prod;
      logic signed [CMP_W-1:0]  val, hi, lo, res;
      prod = a * $signed({1'b0, g});
      prod = prod >>> 4;
      val = {{(CMP_W-PROD_W){prod[PROD_W-1]}}, prod};
      hi = '0;
      hi[OUT_W-2:0] = '1;
      lo = '1;
      lo[OUT_W-2:0] = '0;
      if (val > hi)      res = hi;
      else if (val < lo) res = lo;
      else               res = val;
      return $signed(res[OUT_W-1:0]);
   endfunction

   assign tick_ok    = bus.i_sample_tick && (state == IDLE);
   assign issue      = (state == SCAN);
   assign last_issue = issue && (scan_idx == VIDX_W'(NUM_VOICES - 1));
   assign drain_done = !vld_p1 && !vld_p2;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.i_sample_tick) state_nxt = SCAN;
         SCAN:    if (last_issue)        state_nxt = DRAIN;
         DRAIN:   if (drain_done)        state_nxt = OUTPUT;
         OUTPUT:                         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.o_busy         = (state != IDLE);
      bus.o_sample_valid = (state == OUTPUT);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n)  scan_idx <= '0;
      else if (tick_ok) scan_idx <= '0;
      else if (issue)   scan_idx <= scan_idx + VIDX_W'(1);
   end

   // Command writes come after the scan write-back so they win on a same-voice collision.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            gate[v]     <= 1'b0;
            tuning[v]   <= '0;
            phase[v]    <= '0;
            velocity[v] <= '0;
         end
      end else begin
         if (issue && gate[scan_idx])
            phase[scan_idx] <= phase[scan_idx] + tuning[scan_idx];
         if (bus.i_cmd_valid) begin
            gate[bus.i_cmd_voice] <= bus.i_cmd_note_on;
            if (bus.i_cmd_note_on) begin
               tuning[bus.i_cmd_voice]   <= bus.i_cmd_tuning;
               velocity[bus.i_cmd_voice] <= bus.i_cmd_velocity;
               phase[bus.i_cmd_voice]    <= '0;
            end
         end
      end
   end

   // S1: voice read; only the phase bits the waveforms need travel on.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) vld_p1 <= 1'b0;
      else            vld_p1 <= issue;
   end

   always_ff @(posedge i_clk) begin
      gate_p1 <= gate[scan_idx];
      vel_p1  <= velocity[scan_idx];
      top_p1  <= phase[scan_idx][PHASE_W-1 -: SAMPLE_W+1];
   end

   // S2: waveform generation.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) vld_p2 <= 1'b0;
      else            vld_p2 <= vld_p1;
   end

   always_ff @(posedge i_clk) begin
      sample_p2 <= wave_gen(top_p1, bus.i_wave_select, gate_p1);
      vel_p2    <= vel_p1;
   end

   // S3: velocity scaling and frame accumulation.
   assign scaled_p2 = scale_vel(sample_p2, vel_p2);

   always_ff @(posedge i_clk) begin
      if (tick_ok)     acc <= '0;
      else if (vld_p2) acc <= acc + {{VIDX_W{scaled_p2[SAMPLE_W-1]}}, scaled_p2};
   end

   // Output: gain and saturation, loaded as the FSM enters OUTPUT.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n)
         sample_q <= '0;
      else if (state == DRAIN && drain_done)
         sample_q <= apply_gain(acc, bus.i_master_gain);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) overrun_q <= 1'b0;
      else            overrun_q <= bus.i_sample_tick && (state != IDLE);
   end

   assign bus.o_sample  = sample_q;
   assign bus.o_overrun = overrun_q;
endmodule
